// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipe_stage_reg: FSM state encodings and default
// bundle widths for the MEM/WB stage.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        PSR_EMPTY = 2'd0,
        PSR_ONE   = 2'd1,
        PSR_TWO   = 2'd2
    } psr_state_e;

    localparam int PSR_CTRL_W = 2;
    localparam int PSR_DATA_W = 35;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear wins over an increment in the same cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush, valid-gated control bundle and a stall-cycle counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int CTRL_W = PSR_CTRL_W,
    parameter int DATA_W = PSR_DATA_W,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    psr_state_e        state;
    psr_state_e        state_nxt;
    logic              accept;
    logic              emit;
    logic              load_in;
    logic              load_skid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign out_valid = (state != PSR_EMPTY);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign occ       = state;
    assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
    assign out_data  = main_data;

    // Main entry takes the input beat when empty or when it is being drained.
    assign load_in   = accept && ((state == PSR_EMPTY) || ((state == PSR_ONE) && emit));
    assign load_skid = SKID && accept && (state == PSR_ONE) && !emit;

    always_comb begin
        // NOTE: next-state defaults to the current state first, so no latch is inferred.
        state_nxt = state;
        if (flush) begin
            state_nxt = PSR_EMPTY;
        end else begin
            case (state)
                PSR_EMPTY: if (accept) state_nxt = PSR_ONE;
                PSR_ONE: begin
                    if (load_skid)           state_nxt = PSR_TWO;
                    else if (!accept && emit) state_nxt = PSR_EMPTY;
                end
                PSR_TWO:   if (emit) state_nxt = PSR_ONE;
                default:   state_nxt = PSR_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PSR_EMPTY;
        else     state <= state_nxt;
    end

    // NOTE: payload registers are reset and flushed so out_data reads 0 afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl <= '0;
            main_data <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
            main_data <= '0;
        end else if (load_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
        end else if ((state == PSR_TWO) && emit) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic ready_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ready_q   <= 1'b1;
                    skid_ctrl <= '0;
                    skid_data <= '0;
                end else begin
                    ready_q <= (state_nxt != PSR_TWO);
                    if (flush) begin
                        skid_ctrl <= '0;
                        skid_data <= '0;
                    end else if (load_skid) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end
                end
            end

            assign in_ready = ready_q;
        end else begin : g_no_skid
            assign in_ready  = out_ready || !out_valid;
            assign skid_ctrl = '0;
            assign skid_data = '0;
        end
    endgenerate

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stall_clr),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=1 instance (CNT_W=4) and one
// SKID=0 instance; monitors pop expected beats whenever a DUT emits.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [34:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_emit1 = 0;
    int n_emit0 = 0;
    beat_t q1[$];
    beat_t q0[$];

    // SKID=1 instance
    logic        flush1 = 0, i1_valid = 0, o1_ready = 0, clr1 = 0;
    logic [1:0]  i1_ctrl = 0;
    logic [34:0] i1_data = 0;
    logic        i1_ready, o1_valid;
    logic [1:0]  o1_ctrl, occ1;
    logic [34:0] o1_data;
    logic [3:0]  stall1;

    // SKID=0 instance
    logic        flush0 = 0, i0_valid = 0, o0_ready = 0, clr0 = 0;
    logic [1:0]  i0_ctrl = 0;
    logic [34:0] i0_data = 0;
    logic        i0_ready, o0_valid;
    logic [1:0]  o0_ctrl, occ0;
    logic [34:0] o0_data;
    logic [15:0] stall0;

    pipe_stage_reg #(.CTRL_W(2), .DATA_W(35), .SKID(1'b1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(i1_valid), .in_ready(i1_ready), .in_ctrl(i1_ctrl), .in_data(i1_data),
        .out_valid(o1_valid), .out_ready(o1_ready), .out_ctrl(o1_ctrl), .out_data(o1_data),
        .occ(occ1), .stall_cnt(stall1), .stall_clr(clr1)
    );

    pipe_stage_reg #(.CTRL_W(2), .DATA_W(35), .SKID(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(i0_valid), .in_ready(i0_ready), .in_ctrl(i0_ctrl), .in_data(i0_data),
        .out_valid(o0_valid), .out_ready(o0_ready), .out_ctrl(o0_ctrl), .out_data(o0_data),
        .occ(occ0), .stall_cnt(stall0), .stall_clr(clr0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ctrl_of(input logic [34:0] v);
        return {v[0], 1'b1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [34:0] v);
        i1_valid = 1'b1; i1_data = v; i1_ctrl = ctrl_of(v);
    endtask

    task automatic drive0(input logic [34:0] v);
        i0_valid = 1'b1; i0_data = v; i0_ctrl = ctrl_of(v);
    endtask

    // Monitor for dut1: emits are checked before the same cycle's accept is queued.
    always @(negedge clk) begin
        beat_t e;
        if (rst || flush1) begin
            q1.delete();
        end else begin
            if (o1_valid && o1_ready) begin
                if (q1.size() == 0) begin
                    check("emit1_unexpected", {29'd0, o1_data}, 64'hdead);
                end else begin
                    e = q1.pop_front();
                    check("emit1_data", {29'd0, o1_data}, {29'd0, e.data});
                    check("emit1_ctrl", {62'd0, o1_ctrl}, {62'd0, e.ctrl});
                end
                n_emit1++;
            end
            if (i1_valid && i1_ready) q1.push_back({i1_ctrl, i1_data});
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            q0.delete();
        end else begin
            if (o0_valid && o0_ready) begin
                if (q0.size() == 0) begin
                    check("emit0_unexpected", {29'd0, o0_data}, 64'hdead);
                end else begin
                    e = q0.pop_front();
                    check("emit0_data", {29'd0, o0_data}, {29'd0, e.data});
                    check("emit0_ctrl", {62'd0, o0_ctrl}, {62'd0, e.ctrl});
                end
                n_emit0++;
            end
            if (i0_valid && i0_ready) q0.push_back({i0_ctrl, i0_data});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", o1_valid, 1'b0);
        check("rst_occ", occ1, 2'd0);
        check("rst_out_data", o1_data, 35'd0);
        check("rst_stall", stall1, 4'd0);
        check("rst_in_ready", i1_ready, 1'b1);
        check("rst_in_ready0", i0_ready, 1'b1);
        @(posedge clk); #3 rst = 1'b0;
        step();

        // Stream 8 beats with out_ready high
        o1_ready = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            drive1(35'(v));
            step();
            check("stream_occ", occ1, 2'd1);
            check("stream_ready", i1_ready, 1'b1);
        end
        i1_valid = 1'b0;
        step();
        check("stream_emits", n_emit1, 8);
        check("stream_stall", stall1, 4'd0);
        check("stream_hold_data", o1_data, 35'h8);
        check("stream_idle_ctrl", o1_ctrl, 2'b00);

        // Backpressure: A, B, C with out_ready low for 3 cycles
        drive1(35'hA);
        step();
        drive1(35'hB);
        o1_ready = 1'b0;
        step();
        check("bp_occ_two", occ1, 2'd2);
        check("bp_ready_low", i1_ready, 1'b0);
        drive1(35'hC);
        step();
        check("bp_ready_low2", i1_ready, 1'b0);
        step();
        o1_ready = 1'b1;
        check("bp_stall3", stall1, 4'd3);
        check("bp_head_A", o1_data, 35'hA);
        step();
        check("bp_occ_one", occ1, 2'd1);
        check("bp_ready_up", i1_ready, 1'b1);
        step();
        check("bp_head_C", o1_data, 35'hC);
        i1_valid = 1'b0;
        step();
        check("bp_drained", occ1, 2'd0);
        check("bp_emits", n_emit1, 11);

        // Flush while in TWO
        o1_ready = 1'b0;
        drive1(35'h11); step();
        drive1(35'h12); step();
        check("fl_occ_two", occ1, 2'd2);
        drive1(35'hD); flush1 = 1'b1;
        step();
        flush1 = 1'b0; i1_valid = 1'b0;
        check("fl_out_valid", o1_valid, 1'b0);
        check("fl_out_ctrl", o1_ctrl, 2'b00);
        check("fl_out_data", o1_data, 35'd0);
        check("fl_occ", occ1, 2'd0);
        check("fl_in_ready", i1_ready, 1'b1);
        // Flush while in ONE with a beat that would otherwise be accepted
        drive1(35'h13); step();
        drive1(35'hD); flush1 = 1'b1;
        step();
        flush1 = 1'b0; i1_valid = 1'b0;
        check("fl1_occ", occ1, 2'd0);
        check("fl_stall_kept", stall1, 4'd6);
        o1_ready = 1'b1;
        step(); step();
        check("fl_no_D", n_emit1, 11);

        // Control gating on a bubble
        i1_valid = 1'b0; i1_ctrl = 2'b11; i1_data = 35'h55;
        step();
        check("gate_ctrl", o1_ctrl, 2'b00);
        check("gate_occ", occ1, 2'd0);

        // Saturation and clear-vs-increment priority
        clr1 = 1'b1; step(); clr1 = 1'b0;
        check("sat_cleared", stall1, 4'd0);
        o1_ready = 1'b0;
        drive1(35'h21); step();
        i1_valid = 1'b0;
        repeat (20) step();
        check("sat_15", stall1, 4'hF);
        clr1 = 1'b1; step(); clr1 = 1'b0;
        check("sat_clr_wins", stall1, 4'd0);
        step();
        check("sat_inc_after", stall1, 4'd1);
        o1_ready = 1'b1; step();
        check("sat_drained", occ1, 2'd0);

        // Asynchronous reset with two beats held
        o1_ready = 1'b0;
        drive1(35'h31); step();
        drive1(35'h32); step();
        check("ar_occ_two", occ1, 2'd2);
        i1_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", o1_valid, 1'b0);
        check("ar_out_ctrl", o1_ctrl, 2'b00);
        check("ar_out_data", o1_data, 35'd0);
        check("ar_occ", occ1, 2'd0);
        check("ar_stall", stall1, 4'd0);
        @(posedge clk); #3 rst = 1'b0;
        step();
        check("ar_in_ready", i1_ready, 1'b1);
        check("ar_idle_occ", occ1, 2'd0);

        // SKID=0: combinational ready
        o0_ready = 1'b0;
        drive0(35'h41); step();
        check("s0_valid", o0_valid, 1'b1);
        check("s0_ready_low", i0_ready, 1'b0);
        drive0(35'h42); step();
        check("s0_hold", o0_data, 35'h41);
        #1 o0_ready = 1'b1;
        #1 check("s0_ready_comb", i0_ready, 1'b1);
        step();
        check("s0_loaded", o0_data, 35'h42);
        check("s0_occ", occ0, 2'd1);
        for (int v = 'h50; v <= 'h53; v++) begin
            drive0(35'(v));
            step();
            check("s0_stream_occ", occ0, 2'd1);
        end
        i0_valid = 1'b0;
        step();
        check("s0_empty", occ0, 2'd0);
        check("s0_stall", stall0, 16'd1);
        check("s0_emits", n_emit0, 6);

        check("q1_empty", q1.size(), 0);
        check("q0_empty", q0.size(), 0);
        check("total_emits1", n_emit1, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
